// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Sequencing controller for a multi-cycle RV32I datapath. A single ALU and a
// single unified memory port are shared between instruction fetch, address
// generation, execute and branch evaluation. This block decodes the opcode
// held in the instruction register, walks each instruction through its
// states, stalls on the memory-ready handshake and counts retired
// instructions. It is the only source of the datapath write strobes.
//
// Ports
//   CLK         in   1   rising-edge clock
//   RESET       in   1   synchronous, active-low reset
//   Op          in   7   Instr[6:0] from the instruction register
//   Funct3      in   3   Instr[14:12]
//   Funct7b5    in   1   Instr[30]
//   Zero        in   1   ALU zero flag
//   MemReady    in   1   memory finished the current access this cycle
//   PCWrite     out  1   PC register load
//   AdrSrc      out  1   memory address select (0 PC, 1 Result)
//   MemWrite    out  1   memory write strobe
//   IRWrite     out  1   instruction register / OldPC load
//   ResultSrc   out  2   00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA     out  2   00 PC, 01 OldPC, 10 SrcA
//   ALUSrcB     out  2   00 WriteData, 01 ImmExt, 10 constant 4
//   ALUControl  out  3   000 add, 001 sub, 010 and, 011 or, 101 slt
//   ImmSrc      out  2   00 I, 01 S, 10 B, 11 J
//   RegWrite    out  1   register file write enable
//   Halted      out  1   high while in HALT
//   State       out  4   current state encoding (debug)
//   InstrCount  out  32  retired-instruction counter
// ---------------------------------------------------------------------------
module multicycle_control_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [6:0]  Op,
  input  logic [2:0]  Funct3,
  input  logic        Funct7b5,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic        Halted,
  output logic [3:0]  State,
  output logic [31:0] InstrCount
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    HALT     = 4'd11
  } stateT;

  localparam logic [6:0] opLoad   = 7'b0000011;
  localparam logic [6:0] opStore  = 7'b0100011;
  localparam logic [6:0] opRType  = 7'b0110011;
  localparam logic [6:0] opIType  = 7'b0010011;
  localparam logic [6:0] opJal    = 7'b1101111;
  localparam logic [6:0] opBranch = 7'b1100011;

  localparam logic [1:0] aluOpAdd    = 2'b00;
  localparam logic [1:0] aluOpSub    = 2'b01;
  localparam logic [1:0] aluOpFunct  = 2'b10;

  stateT      stateReg;
  stateT      stateNext;
  stateT      activeState;
  logic [1:0] aluOp;
  logic       pcUpdate;
  logic       branch;
  logic       irWriteRaw;
  logic       memWriteRaw;
  logic       regWriteRaw;
  logic       retire;

  // While reset is held, the outputs must look exactly like a FETCH cycle no
  // matter what state the register still holds, so everything downstream
  // decodes from this "effective" state rather than the raw register. The
  // write strobes are additionally gated by RESET further down so that an
  // instruction abandoned by reset never writes anything.
  always_comb begin
    activeState = RESET ? stateReg : FETCH;
  end

  assign State = activeState;

  // State register and retired-instruction counter. Reset is synchronous and
  // takes priority over retirement, so an instruction cut short by reset is
  // never counted. The counter simply wraps at 32 bits.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stateReg   <= FETCH;
      InstrCount <= '0;
    end else begin
      stateReg <= stateNext;
      if (retire) begin
        InstrCount <= InstrCount + 32'd1;
      end
    end
  end

  // Next-state and per-state control decode. Every control signal starts at
  // zero and each state only raises what it needs. FETCH, MEMREAD and
  // MEMWRITE are the memory-touching states, so they hold until MemReady.
  // The fetch itself (IR load and PC+4) only commits on the ready cycle so a
  // stalled fetch does not advance the PC. Unused encodings 12-15 fall into
  // the default arm and recover to FETCH with all strobes low.
  always_comb begin
    stateNext   = FETCH;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    aluOp       = aluOpAdd;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    irWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    Halted      = 1'b0;
    retire      = 1'b0;

    case (activeState)
      FETCH: begin
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b10;
        aluOp     = aluOpAdd;
        ResultSrc = 2'b10;
        if (MemReady) begin
          irWriteRaw = 1'b1;
          pcUpdate   = 1'b1;
          stateNext  = DECODE;
        end else begin
          stateNext = FETCH;
        end
      end

      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        aluOp   = aluOpAdd;
        case (Op)
          opLoad,
          opStore:  stateNext = MEMADR;
          opRType:  stateNext = EXECUTER;
          opIType:  stateNext = EXECUTEI;
          opJal:    stateNext = JAL;
          opBranch: stateNext = BEQ;
          default:  stateNext = HALT;
        endcase
      end

      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        aluOp     = aluOpAdd;
        stateNext = (Op == opLoad) ? MEMREAD : MEMWRITE;
      end

      MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        stateNext = MemReady ? MEMWB : MEMREAD;
      end

      MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
        retire      = 1'b1;
        stateNext   = FETCH;
      end

      MEMWRITE: begin
        AdrSrc      = 1'b1;
        ResultSrc   = 2'b00;
        memWriteRaw = 1'b1;
        if (MemReady) begin
          retire    = 1'b1;
          stateNext = FETCH;
        end else begin
          stateNext = MEMWRITE;
        end
      end

      EXECUTER: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        aluOp     = aluOpFunct;
        stateNext = ALUWB;
      end

      EXECUTEI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        aluOp     = aluOpFunct;
        stateNext = ALUWB;
      end

      ALUWB: begin
        ResultSrc   = 2'b00;
        regWriteRaw = 1'b1;
        retire      = 1'b1;
        stateNext   = FETCH;
      end

      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        aluOp     = aluOpAdd;
        ResultSrc = 2'b00;
        pcUpdate  = 1'b1;
        stateNext = ALUWB;
      end

      BEQ: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        aluOp     = aluOpSub;
        ResultSrc = 2'b00;
        branch    = 1'b1;
        retire    = 1'b1;
        stateNext = FETCH;
      end

      HALT: begin
        Halted    = 1'b1;
        stateNext = HALT;
      end

      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // Write strobes. The branch term is combinational on Zero so the PC load
  // tracks the comparison result within the BEQ cycle. All four strobes are
  // held low while reset is asserted.
  always_comb begin
    PCWrite  = RESET & (pcUpdate | (branch & Zero));
    IRWrite  = RESET & irWriteRaw;
    MemWrite = RESET & memWriteRaw;
    RegWrite = RESET & regWriteRaw;
  end

  // ALU operation decode. Funct7b5 only selects subtract for register-register
  // ops (Op[5] set); for immediates that bit belongs to the immediate field,
  // so addi must stay an add. Unlisted funct3 values fall back to add.
  always_comb begin
    ALUControl = 3'b000;
    case (aluOp)
      aluOpAdd: ALUControl = 3'b000;
      aluOpSub: ALUControl = 3'b001;
      aluOpFunct: begin
        case (Funct3)
          3'b000:  ALUControl = (Op[5] & Funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format select depends only on the opcode and is valid in every
  // state, which lets DECODE compute the branch target with the right format.
  always_comb begin
    ImmSrc = 2'b00;
    case (Op)
      opLoad,
      opIType:  ImmSrc = 2'b00;
      opStore:  ImmSrc = 2'b01;
      opBranch: ImmSrc = 2'b10;
      opJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed bench for the multi-cycle controller. Each instruction is walked
// cycle by cycle with hand-derived expected state and strobe values; a few
// extra per-state checks cover the mux selects, ALU decode and immediate
// format. Inputs change just after a rising edge and outputs are sampled
// 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic        CLK;
  logic        RESET;
  logic [6:0]  Op;
  logic [2:0]  Funct3;
  logic        Funct7b5;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic        Halted;
  logic [3:0]  State;
  logic [31:0] InstrCount;

  logic [4:0]  strobes;
  int          totalChecks;
  int          badChecks;

  multicycle_control_unit dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Op         (Op),
    .Funct3     (Funct3),
    .Funct7b5   (Funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .Halted     (Halted),
    .State      (State),
    .InstrCount (InstrCount)
  );

  // Strobe bundle {PCWrite, IRWrite, MemWrite, RegWrite, Halted} so each
  // cycle can be checked against one hand-written 5-bit constant.
  assign strobes = {PCWrite, IRWrite, MemWrite, RegWrite, Halted};

  // Free-running 100 MHz clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Load the instruction fields the controller sees from the IR.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic f7b5);
    Op       = op;
    Funct3   = f3;
    Funct7b5 = f7b5;
  endtask

  // Advance one clock and step just past the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive the handshake inputs for the current cycle, then check the state
  // and the strobe bundle. Does not advance the clock.
  task automatic runCycle(input string tag, input logic mr, input logic zr,
                          input logic [3:0] expState,
                          input logic [4:0] expStrobes);
    MemReady = mr;
    Zero     = zr;
    #1;
    checkOutput({tag, ".state"}, 32'(State), 32'(expState));
    checkOutput({tag, ".strobes"}, 32'(strobes), 32'(expStrobes));
  endtask

  // Common FETCH (ready) and DECODE cycles for every instruction.
  task automatic fetchDecode(input string tag);
    runCycle({tag, ".fetch"}, 1'b1, 1'b0, 4'd0, 5'b11000);
    tick();
    runCycle({tag, ".decode"}, 1'b1, 1'b0, 4'd1, 5'b00000);
    checkOutput({tag, ".decSrcA"}, 32'(ALUSrcA), 32'd1);
    checkOutput({tag, ".decSrcB"}, 32'(ALUSrcB), 32'd1);
    tick();
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    RESET       = 1'b0;
    MemReady    = 1'b1;
    Zero        = 1'b0;
    applyStimulus(7'b0110011, 3'b000, 1'b1);

    // Reset held for two edges with MemReady high: no strobes, FETCH view.
    tick();
    tick();
    runCycle("rst", 1'b1, 1'b0, 4'd0, 5'b00000);
    checkOutput("rst.count", InstrCount, 32'd0);
    checkOutput("rst.srcB", 32'(ALUSrcB), 32'd2);

    // Release: first FETCH cycle commits immediately.
    RESET = 1'b1;
    runCycle("rel", 1'b1, 1'b0, 4'd0, 5'b11000);
    checkOutput("rel.srcB", 32'(ALUSrcB), 32'd2);
    checkOutput("rel.result", 32'(ResultSrc), 32'd2);
    tick();

    // R-type sub: FETCH already checked above, continue from DECODE.
    runCycle("sub.decode", 1'b1, 1'b0, 4'd1, 5'b00000);
    tick();
    runCycle("sub.exec", 1'b1, 1'b0, 4'd6, 5'b00000);
    checkOutput("sub.aluCtl", 32'(ALUControl), 32'd1);
    checkOutput("sub.srcA", 32'(ALUSrcA), 32'd2);
    checkOutput("sub.srcB", 32'(ALUSrcB), 32'd0);
    tick();
    runCycle("sub.wb", 1'b1, 1'b0, 4'd7, 5'b00010);
    checkOutput("sub.wbResult", 32'(ResultSrc), 32'd0);
    tick();
    checkOutput("sub.count", InstrCount, 32'd1);

    // lw with three stalled MEMREAD cycles.
    applyStimulus(7'b0000011, 3'b010, 1'b0);
    fetchDecode("lw");
    runCycle("lw.adr", 1'b1, 1'b0, 4'd2, 5'b00000);
    checkOutput("lw.imm", 32'(ImmSrc), 32'd0);
    checkOutput("lw.adrSrcA", 32'(ALUSrcA), 32'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      runCycle("lw.readStall", 1'b0, 1'b0, 4'd3, 5'b00000);
      checkOutput("lw.adrSrc", 32'(AdrSrc), 32'd1);
      tick();
    end
    runCycle("lw.readDone", 1'b1, 1'b0, 4'd3, 5'b00000);
    tick();
    runCycle("lw.wb", 1'b1, 1'b0, 4'd4, 5'b00010);
    checkOutput("lw.wbResult", 32'(ResultSrc), 32'd1);
    tick();
    checkOutput("lw.count", InstrCount, 32'd2);

    // sw with two stalled MEMWRITE cycles; count moves only on exit.
    applyStimulus(7'b0100011, 3'b010, 1'b0);
    fetchDecode("sw");
    runCycle("sw.adr", 1'b1, 1'b0, 4'd2, 5'b00000);
    checkOutput("sw.imm", 32'(ImmSrc), 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      runCycle("sw.writeStall", 1'b0, 1'b0, 4'd5, 5'b00100);
      checkOutput("sw.adrSrc", 32'(AdrSrc), 32'd1);
      checkOutput("sw.countHeld", InstrCount, 32'd2);
      tick();
    end
    runCycle("sw.writeDone", 1'b1, 1'b0, 4'd5, 5'b00100);
    tick();
    checkOutput("sw.count", InstrCount, 32'd3);
    checkOutput("sw.backToFetch", 32'(State), 32'd0);

    // beq taken.
    applyStimulus(7'b1100011, 3'b000, 1'b0);
    fetchDecode("beq1");
    runCycle("beq1.br", 1'b1, 1'b1, 4'd10, 5'b10000);
    checkOutput("beq1.aluCtl", 32'(ALUControl), 32'd1);
    checkOutput("beq1.imm", 32'(ImmSrc), 32'd2);
    tick();
    checkOutput("beq1.count", InstrCount, 32'd4);

    // beq not taken, then Zero rises inside the same BEQ cycle.
    fetchDecode("beq0");
    runCycle("beq0.br", 1'b1, 1'b0, 4'd10, 5'b00000);
    Zero = 1'b1;
    #1;
    checkOutput("beq0.zeroLive", 32'(PCWrite), 32'd1);
    Zero = 1'b0;
    tick();
    checkOutput("beq0.fetch", 32'(State), 32'd0);
    checkOutput("beq0.count", InstrCount, 32'd5);

    // addi with Instr[30]=1 must still add (Op[5]=0).
    applyStimulus(7'b0010011, 3'b000, 1'b1);
    fetchDecode("addi");
    runCycle("addi.exec", 1'b1, 1'b0, 4'd8, 5'b00000);
    checkOutput("addi.aluCtl", 32'(ALUControl), 32'd0);
    checkOutput("addi.srcB", 32'(ALUSrcB), 32'd1);
    tick();
    runCycle("addi.wb", 1'b1, 1'b0, 4'd7, 5'b00010);
    tick();
    checkOutput("addi.count", InstrCount, 32'd6);

    // jal.
    applyStimulus(7'b1101111, 3'b000, 1'b0);
    fetchDecode("jal");
    runCycle("jal.jump", 1'b1, 1'b0, 4'd9, 5'b10000);
    checkOutput("jal.imm", 32'(ImmSrc), 32'd3);
    checkOutput("jal.srcA", 32'(ALUSrcA), 32'd1);
    checkOutput("jal.srcB", 32'(ALUSrcB), 32'd2);
    tick();
    runCycle("jal.wb", 1'b1, 1'b0, 4'd7, 5'b00010);
    tick();
    checkOutput("jal.count", InstrCount, 32'd7);

    // R-type slt and or: ALU decode in EXECUTER.
    applyStimulus(7'b0110011, 3'b010, 1'b0);
    fetchDecode("slt");
    runCycle("slt.exec", 1'b1, 1'b0, 4'd6, 5'b00000);
    checkOutput("slt.aluCtl", 32'(ALUControl), 32'd5);
    Funct3 = 3'b110;
    #1;
    checkOutput("or.aluCtl", 32'(ALUControl), 32'd3);
    Funct3 = 3'b111;
    #1;
    checkOutput("and.aluCtl", 32'(ALUControl), 32'd2);
    tick();
    runCycle("slt.wb", 1'b1, 1'b0, 4'd7, 5'b00010);
    tick();
    checkOutput("slt.count", InstrCount, 32'd8);

    // Illegal opcode parks in HALT with no strobes even when Zero is high.
    applyStimulus(7'b1111111, 3'b000, 1'b0);
    fetchDecode("ill");
    for (int i = 0; i < 10; i++) begin
      runCycle("ill.halt", 1'b1, 1'b1, 4'd11, 5'b00001);
      tick();
    end
    checkOutput("ill.count", InstrCount, 32'd8);

    // Reset out of HALT.
    RESET = 1'b0;
    runCycle("ill.rstView", 1'b1, 1'b0, 4'd0, 5'b00000);
    tick();
    runCycle("ill.rstHeld", 1'b1, 1'b0, 4'd0, 5'b00000);
    checkOutput("ill.rstCount", InstrCount, 32'd0);
    RESET = 1'b1;
    runCycle("ill.restart", 1'b1, 1'b0, 4'd0, 5'b11000);
    tick();
    checkOutput("ill.decodeAgain", 32'(State), 32'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
